// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter via din_tx/data_update, paced by done_tx.
// Define UART_TXF_TIMEOUT_EN to add the done_tx watchdog (timeout_err).
module uart_tx_fifo #(
    parameter int DEPTH          = 16,
    parameter int UPD_HOLD       = 128,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [7:0]                 din_tx,
    output logic                       data_update,
    input  logic                       done_tx,
    output logic                       busy,
    output logic                       sent,
    output logic                       timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = $clog2(UPD_HOLD);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [HW-1:0] HOLD_LAST = HW'(UPD_HOLD - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        UPD_HOLD < 2 || TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("uart_tx_fifo: illegal parameter value");
    end

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    din_q, din_d;
    logic          upd_q, upd_d;
    logic          seen_q, seen_d;
    logic          sent_q, sent_d;
    logic          ovf_q;
    logic          done_q;
    logic          push, pop, done_rise;

`ifdef UART_TXF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wd_q, wd_d;
    logic          terr_q, terr_d;

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign din_tx      = din_q;
    assign data_update = upd_q;
    assign busy        = (state_q != S_IDLE);
    assign sent        = sent_q;

    // Full is judged on the pre-edge count, so a same-cycle pop cannot make room.
    assign push      = wr_en && !full;
    assign done_rise = done_tx && !done_q;

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        upd_d   = upd_q;
        hold_d  = hold_q;
        seen_d  = seen_q;
        sent_d  = 1'b0;
        pop     = 1'b0;
`ifdef UART_TXF_TIMEOUT_EN
        wd_d    = wd_q;
        terr_d  = terr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    din_d   = mem_q[rd_ptr_q];
                    upd_d   = 1'b1;
                    hold_d  = '0;
                    seen_d  = 1'b0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                seen_d = seen_q | done_rise;
                if (hold_q == HOLD_LAST) begin
                    upd_d   = 1'b0;
                    state_d = S_WAIT;
`ifdef UART_TXF_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (done_rise || seen_q) begin
                    sent_d  = 1'b1;
                    seen_d  = 1'b0;
                    state_d = S_IDLE;
                end
`ifdef UART_TXF_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            hold_q   <= '0;
            din_q    <= 8'h00;
            upd_q    <= 1'b0;
            seen_q   <= 1'b0;
            sent_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            din_q   <= din_d;
            upd_q   <= upd_d;
            seen_q  <= seen_d;
            sent_q  <= sent_d;
            ovf_q   <= ovf_q | (wr_en && full);
            done_q  <= done_tx;
        end
    end

`ifdef UART_TXF_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based transaction model,
// plus directed literal checks of reset, hold length, overflow, ordering and reset abort.
module tb_uart_tx_fifo;
    localparam int DEPTH    = 16;
    localparam int UPD_HOLD = 128;
    localparam int TOUT     = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       done_tx = 1'b0;
    logic       full, empty, overflow, data_update, busy, sent, timeout_err;
    logic [4:0] count;
    logic [7:0] din_tx;

    uart_tx_fifo #(
        .DEPTH(DEPTH),
        .UPD_HOLD(UPD_HOLD),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .din_tx(din_tx),
        .data_update(data_update),
        .done_tx(done_tx),
        .busy(busy),
        .sent(sent),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a queue of pending bytes and the age of the byte on the line.
    logic [7:0] mq[$];
    logic [7:0] m_din = 8'h00;
    bit m_busy = 0, m_seen = 0, m_sent = 0, m_ovf = 0, m_terr = 0, m_prev = 0;
    int m_age = 0;

    task automatic model_step();
        int n;
        bit rise;
        if (rst) begin
            mq.delete();
            m_din = 8'h00; m_busy = 0; m_seen = 0; m_sent = 0;
            m_ovf = 0; m_terr = 0; m_prev = 0; m_age = 0;
            return;
        end
        rise   = done_tx && !m_prev;
        m_prev = done_tx;
        n      = mq.size();
        m_sent = 0;
        if (!m_busy) begin
            if (n > 0) begin
                m_din  = mq.pop_front();
                m_busy = 1; m_age = 0; m_seen = 0;
            end
        end else if (m_age < UPD_HOLD) begin
            m_seen = m_seen | rise;
            m_age++;
        end else if (rise || m_seen) begin
            m_sent = 1; m_busy = 0;
        end
`ifdef UART_TXF_TIMEOUT_EN
        else if (m_age - UPD_HOLD == TOUT - 1) begin
            m_terr = 1; m_busy = 0;
        end
`endif
        else begin
            m_age++;
        end
        if (wr_en) begin
            if (n == DEPTH) m_ovf = 1;
            else mq.push_back(wr_data);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("m_count", count, mq.size());
            chk("m_empty", empty, mq.size() == 0);
            chk("m_full", full, mq.size() == DEPTH);
            chk("m_overflow", overflow, m_ovf);
            chk("m_din_tx", din_tx, m_din);
            chk("m_data_update", data_update, m_busy && m_age < UPD_HOLD);
            chk("m_busy", busy, m_busy);
            chk("m_sent", sent, m_sent);
            chk("m_timeout_err", timeout_err, m_terr);
        end
    end

    task automatic wait_du(input logic val, input string name);
        for (int i = 0; i < 3000 && data_update !== val; i++) @(negedge clk);
        chk(name, data_update, val);
    endtask

    task automatic pulse_done();
        done_tx = 1'b1;
        @(negedge clk);
        done_tx = 1'b0;
    endtask

    task automatic push1(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        int hi;
        bit saw;
        logic [7:0] b;
        int pct;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_du", data_update, 0);
        chk("rst_din", din_tx, 8'h00);
        chk("rst_busy", busy, 0);

        push1(8'hA5);
        chk("a5_count_after_write", count, 1);
        chk("a5_du_before_pop", data_update, 0);
        @(negedge clk);
        chk("a5_du", data_update, 1);
        chk("a5_din", din_tx, 8'hA5);
        chk("a5_count", count, 0);
        chk("a5_busy", busy, 1);
        hi = 1;
        for (int i = 0; i < 1000 && data_update; i++) begin
            @(negedge clk);
            if (data_update) hi++;
        end
        chk("a5_hold_len", hi, 128);
        chk("a5_busy_wait", busy, 1);
        pulse_done();
        chk("a5_sent", sent, 1);
        chk("a5_idle", busy, 0);
        @(negedge clk);
        chk("a5_sent_once", sent, 0);

        push1(8'hFF);
        @(negedge clk);
        chk("ff_issued", din_tx, 8'hFF);
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("burst_full", full, 1);
        chk("burst_count", count, 16);
        chk("burst_no_ovf", overflow, 0);
        push1(8'h77);
        chk("burst_ovf", overflow, 1);
        chk("burst_count_kept", count, 16);
        wait_du(1'b0, "ff_du_fall");
        pulse_done();
        chk("ff_sent", sent, 1);
        wr_en = 1'b1; wr_data = 8'h88;
        @(negedge clk);
        wr_en = 1'b0;
        chk("pop_wr_count", count, 15);
        chk("pop_wr_ovf", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            wait_du(1'b1, "drain_du_rise");
            b = din_tx;
            chk("drain_order", b, 8'(i));
            wait_du(1'b0, "drain_du_fall");
            pulse_done();
        end
        @(negedge clk);
        chk("drain_empty", empty, 1);
        chk("drain_idle", busy, 0);

        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("rsthold_count", count, 5);
        chk("rsthold_du", data_update, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rsthold_count0", count, 0);
        chk("rsthold_du0", data_update, 0);
        chk("rsthold_busy0", busy, 0);
        chk("rsthold_ovf0", overflow, 0);
        saw = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sent || busy) saw = 1;
        end
        chk("rsthold_no_replay", saw, 0);

        push1(8'h5A);
        wait_du(1'b1, "wd_du_rise");
        wait_du(1'b0, "wd_du_fall");
        repeat (TOUT + 60) @(negedge clk);
`ifdef UART_TXF_TIMEOUT_EN
        chk("wd_terr", timeout_err, 1);
        chk("wd_idle", busy, 0);
`else
        chk("wd_no_terr", timeout_err, 0);
        chk("wd_still_waiting", busy, 1);
`endif
        pulse_done();
        repeat (2) @(negedge clk);

        pct = 30;
        for (int c = 0; c < 20000; c++) begin
            if (c % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0: pct = 5;
                    1: pct = 40;
                    default: pct = 90;
                endcase
            end
            wr_en   = ($urandom_range(0, 99) < pct);
            wr_data = 8'($urandom);
            if ($urandom_range(0, 1) == 0) done_tx = ($urandom_range(0, 99) < 4);
            else if ($urandom_range(0, 99) < 2) done_tx = ~done_tx;
            rst = ($urandom_range(0, 3999) == 0);
            @(negedge clk);
        end
        rst = 1'b0; wr_en = 1'b0; done_tx = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO that sits directly upstream of the UART transmit path in UART_Top and drives its din_tx/data_update inputs.
- Host logic pushes bytes at full clock rate. The block releases them one at a time and waits for the transmitter's done_tx before issuing the next byte.
- Decouples bursty producers from the 9600-baud serial line.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- UPD_HOLD, 128, clk cycles data_update is held high per byte; must exceed one uart_clk period (clk_freq/baud, ~104 at 1 MHz/9600).
- TIMEOUT_CYCLES, 2048, done_tx watchdog limit; used only with UART_TXF_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  push wr_data this cycle
- wr_data  in  8  byte to queue
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH+1)  occupancy
- overflow  out  1  sticky: write attempted while full
- din_tx  out  8  byte presented to transmitter
- data_update  out  1  new-data strobe to transmitter
- done_tx  in  1  transmitter completion, level or pulse; rising edge used
- busy  out  1  FSM not IDLE
- sent  out  1  one-cycle pulse per completed byte
- timeout_err  out  1  sticky watchdog error; tied 0 without macro

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: count 0, empty 1, full 0, overflow 0, din_tx 8'h00, data_update 0, busy 0, sent 0, timeout_err 0, pointers 0, FSM IDLE, done_tx edge register 0.
- Reset mid-transfer: the FIFO is discarded and data_update drops on the reset edge. No partial byte is replayed.
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0. count is tracked separately.
- Write: accepted when wr_en && !full, evaluated on the pre-edge count.
  - Write while full is dropped, even if a pop occurs the same cycle, and sets overflow.
  - overflow clears only on rst.
- Pop: performed only by the FSM on IDLE->HOLD.
  - Simultaneous accepted write and pop leaves count unchanged; both pointers advance.
- done_tx edge detect: done_rise = done_tx && !done_tx_q.
- FSM states:
  - IDLE: if !empty, latch head into din_tx, pop, set data_update=1, clear hold counter, go HOLD.
    - A byte written into an empty FIFO at edge N is popped at edge N+1; data_update is high from N+1.
  - HOLD: data_update=1; count to UPD_HOLD-1, then data_update=0 and go WAIT_DONE.
    - done_rise seen in HOLD is recorded and honoured on entry to WAIT_DONE.
  - WAIT_DONE: data_update=0, din_tx stable. On done_rise (or recorded flag), pulse sent for 1 cycle and go IDLE.
    - The next byte, if queued, is popped in the following cycle, giving a minimum 1-cycle IDLE gap.
- din_tx changes only on IDLE->HOLD.
- busy = (state != IDLE).
- done_rise in IDLE is ignored.

Optional Feature:
- Macro UART_TXF_TIMEOUT_EN.
- Defined: a watchdog counts cycles in WAIT_DONE. When it reaches TIMEOUT_CYCLES without done_rise:
  - set timeout_err (sticky until rst);
  - abandon the byte (no sent pulse);
  - return to IDLE and continue with the next byte.
- Not defined: WAIT_DONE waits indefinitely, timeout_err is constant 0, and the counter logic is not synthesized.

Test Plan:
- Reset then idle -> empty=1, count=0, data_update=0, din_tx=8'h00, busy=0.
- Push 8'hA5 into empty FIFO, hold done_tx low -> next edge data_update=1, din_tx=A5, count=0, busy=1. data_update stays high exactly 128 cycles, then low. Pulse done_tx -> sent pulse 1 cycle, busy=0.
- Burst-push 16 bytes 8'h00..8'h0F while FSM holds byte 0 -> full=1 after the 16th accepted write. A 17th push sets overflow=1 and count stays 16. Completions return the bytes in order 00..0F and pointers wrap correctly.
- Full FIFO, wr_en on the same cycle as IDLE pop -> write rejected, overflow=1, count drops to 15.
- Assert rst during HOLD with 5 bytes queued -> next edge count=0, data_update=0, busy=0, and no sent pulse afterward.
- With UART_TXF_TIMEOUT_EN and TIMEOUT_CYCLES=2048, keep done_tx low -> after 2048 WAIT_DONE cycles timeout_err=1, no sent pulse, and the next queued byte is issued. Without the macro the FSM stays in WAIT_DONE.
